// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the byte-lane enable function used by the store merge.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] lane_mask(lsu_size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(lsu_size_e size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  // valid/ready: a beat transfers on a rising edge where both are 1; the
  // sender holds valid and its payload stable until that edge.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into a previously read word (little-endian lanes).
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] rd_word,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [3:0]  mask;
  logic [31:0] rep;

  always_comb begin
    lane_b    = rd_word[{off, 3'b000} +: 8];
    lane_h    = rd_word[{off[1], 4'b0000} +: 16];
    load_data = rd_word;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated to every lane; the mask picks which ones land.
  always_comb begin
    mask = lane_mask(size, off);
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    store_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) store_word[8*i +: 8] = rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors;
// otherwise the low address bits are forced to the access alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  load_store_unit_if.slave   bus,
  output logic               mem_we,
  output logic [31:0]        mem_a,
  output logic [31:0]        mem_wd,
  input  logic [31:0]        mem_rd,
  output lsu_state_e         dbg_state
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_e         size_q;
  logic              signed_q, we_q;
  logic [31:0]       wdata_q, buf_q, rdata_q;
  logic              err_q;

  lsu_size_e         req_sz;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W:0]   end_addr;
  logic              misalign_err, req_err, accept;
  logic [31:0]       load_data, store_word;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign req_sz = lsu_size_e'(bus.req_size);

  always_comb begin
    eff_addr     = bus.req_addr;
    misalign_err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err = ((req_sz == SZ_HALF) && bus.req_addr[0]) ||
                   ((req_sz == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    if (req_sz == SZ_HALF) eff_addr[0]   = 1'b0;
    if (req_sz == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
    // One extra bit so an address near the top of the space cannot wrap.
    end_addr = {1'b0, eff_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(req_sz)};
    req_err  = (req_sz == SZ_RSVD) || misalign_err || (end_addr > MEM_LIMIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    mem_we        = 1'b0;
    mem_a         = '0;
    mem_wd        = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err)                                state_d = RSP;
          else if (bus.req_we && req_sz == SZ_WORD)   state_d = WR;
          else                                        state_d = RD;
        end
      end
      RD: begin
        mem_a   = 32'({addr_q[ADDR_W-1:2], 2'b00});
        state_d = we_q ? WR : RSP;
      end
      WR: begin
        mem_we  = 1'b1;
        mem_a   = 32'({addr_q[ADDR_W-1:2], 2'b00});
        mem_wd  = store_word;
        state_d = RSP;
      end
      RSP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= eff_addr;
        size_q   <= req_sz;
        signed_q <= bus.req_signed;
        we_q     <= bus.req_we;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state_q == RD) begin
        buf_q <= mem_rd;
        if (!we_q) rdata_q <= load_data;
      end
      if (state_q == RSP && bus.resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state_q;

  lsu_align u_align (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .sign_ext   (signed_q),
    .rd_word    (mem_rd),
    .load_data  (load_data),
    .old_word   (buf_q),
    .wdata      (wdata_q),
    .store_word (store_word)
  );

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side companion to the byte-addressed data memory: accepts CPU load/store requests and drives the memory's WE/WD/A, reading its combinational RD.
- Adds byte and halfword accesses, sign/zero extension, alignment and range checking, and read-modify-write for sub-word stores.
- The memory itself only transfers whole 4-byte little-endian words.
- Sits between the execute stage and the data memory; turns single-cycle memory access into a request/response handshake.

Parameters:
- MEM_BYTES, 16, size of the attached memory in bytes; addresses at or above it are errors.
- ADDR_W, 32, address width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_signed  in  1  sign-extend loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range, or reserved size
- mem_we  out  1  to memory WE
- mem_a  out  32  to memory A, always word-aligned
- mem_wd  out  32  to memory WD
- mem_rd  in  32  from memory RD, combinational

Behaviour:
- Reset, async on reset_n = 0:
  - state = IDLE.
  - mem_we = 0, mem_a = 0, mem_wd = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready = 1.
- Reset mid-access drops mem_we immediately. A store in flight may be lost; memory is never partially written by this unit.
- req_ready = (state == IDLE).
- A request is accepted on a clock edge with req_valid & req_ready. Address, size, signed, we and wdata are latched.
- FSM states: IDLE, RD, WR, RSP.
- IDLE, on accept:
  - Error condition → RSP with resp_err = 1. No memory cycle.
  - Store word → WR.
  - Otherwise → RD.
- Error conditions:
  - req_size == 3.
  - Address misaligned for its size: half needs addr[0] = 0; word needs addr[1:0] = 0.
  - addr + bytes > MEM_BYTES.
- RD, one cycle:
  - mem_a = {addr[31:2], 2'b00}.
  - mem_rd is captured into the word buffer at the end of the cycle.
  - Load → RSP, with byte/half extracted at lane addr[1:0] and extended per req_signed.
  - Sub-word store → WR.
- WR, one cycle:
  - mem_we = 1.
  - mem_a = aligned address.
  - mem_wd = buffer with the selected lanes replaced by req_wdata[7:0] or [15:0]; a word store replaces the whole word.
  - → RSP.
- RSP: resp_valid = 1 and data/err held stable until resp_ready. Then → IDLE on the same edge.
- Latency from accept edge to resp_valid:
  - Load: 2 cycles.
  - Store word: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- mem_we is 1 only in WR, and for exactly one cycle per store.
- mem_a and mem_wd are 0 in IDLE and RSP.
- Back-to-back operation: a new request is accepted only after the response handshake. The maximum rate is one request every 3–4 cycles.
- Little-endian: lane 0 = addr[1:0] == 0 = bits [7:0].

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses produce resp_err = 1 and no memory cycle, as above.
- Undefined:
  - Misalignment is not an error; the low address bits are forced (half: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds.
  - Range and reserved-size errors still apply.

Decomposition:
- Shared package `lsu_pkg`:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state enum.
  - Function `lane_mask(size, off)` returning a 4-bit byte enable.
- Sub-module `lsu_align`, purely combinational:
  - Load extraction/extension.
  - Store merge.
  - Instantiated once; unit-testable on its own.

Test Plan:
- Memory preset so word 12 = 0x00000203. Load word at 12 → resp_rdata 0x00000203, err 0, resp_valid 2 cycles after accept, mem_we never 1.
- Store byte 0xFF at addr 5, word 4 = 0x00000001 → RD then WR with mem_a 4, mem_wd 0x0000FF01, one mem_we pulse. Then signed byte load at 5 → 0xFFFFFFFF; unsigned → 0x000000FF.
- Store word 0xDEADBEEF at 8 → no RD cycle, mem_wd 0xDEADBEEF. Load half signed at 10 → 0xFFFFDEAD.
- Load half at 13 with LSU_MISALIGN_TRAP_EN → resp_err 1, rdata 0, no memory cycle. Without the macro → reads addr 12, rdata 0x00000203.
- Load word at 16 and store byte at 0x20 → resp_err 1; memory unchanged, mem_we never asserted.
- Hold resp_ready = 0 for 5 cycles → resp stays stable, req_ready 0. Assert reset_n = 0 during WR of a store → mem_we 0 immediately, all outputs at reset values, req_ready 1.
